// File: rtl/hdmi_tx_rst_pkg.sv
// Shared definitions for the HDMI TX reset sequencer: state encoding and
// default parameter values.
package hdmi_tx_rst_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        WAIT_READY = 2'd1,
        RUN        = 2'd2,
        ERROR      = 2'd3
    } seq_state_e;

    localparam int DEF_NUM_LANES    = 4;
    localparam int DEF_RST_HOLD_CYC = 16;
    localparam int DEF_STABLE_CYC   = 8;
    localparam int DEF_TIMEOUT_CYC  = 1000000;
    localparam int DEF_MAX_RETRY    = 3;
    localparam int DEF_CNT_W        = 20;

endpackage

// File: rtl/hdmi_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared to 0 on reset.
module hdmi_sync_2ff (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/hdmi_tx_rst_seq.sv
// Reset sequencer in front of the 4-lane HDMI TX reset controller: holds the
// controller in reset, waits for stable lane readiness, then opens the data path.
//
// state      | meaning
// -----------+------------------------------------------------------------
// RESET_HOLD | xcvr_reset asserted, counting the hold time
// WAIT_READY | reset released, waiting for all lanes ready + PLL lock, stable
// RUN        | link up, TMDS data launch enabled
// ERROR      | retries exhausted, lanes held in reset until a rate change
module hdmi_tx_rst_seq
    import hdmi_tx_rst_pkg::*;
#(
    parameter int NUM_LANES    = DEF_NUM_LANES,
    parameter int RST_HOLD_CYC = DEF_RST_HOLD_CYC,
    parameter int STABLE_CYC   = DEF_STABLE_CYC,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rate_change_req,
    input  logic                 rate_sel,
    input  logic                 pll_locked,
    input  logic [NUM_LANES-1:0] tx_ready,
    input  logic [NUM_LANES-1:0] tx_cal_busy,
    output logic                 xcvr_reset,
    output logic                 pll_select,
    output logic                 tx_data_en,
    output logic                 seq_busy,
    output logic                 seq_error,
    output logic [3:0]           retry_cnt
);

    localparam int STAB_W = $clog2(STABLE_CYC + 1);

    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(STABLE_CYC - 1);
    localparam logic [STAB_W-1:0] STAB_MAX   = '1;
    localparam logic [3:0]        RETRY_MAX  = 4'(MAX_RETRY);

    seq_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [STAB_W-1:0] stab_cnt, stab_nxt;
    logic [3:0]        retry_nxt;
    logic              pll_sel_nxt;

    logic pll_locked_sync;
    logic all_ok;
    logic cal_busy;

    hdmi_sync_2ff u_pll_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (pll_locked),
        .dout    (pll_locked_sync)
    );

    assign all_ok   = (&tx_ready) & pll_locked_sync;
    assign cal_busy = |tx_cal_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RESET_HOLD;
            cnt        <= '0;
            stab_cnt   <= '0;
            retry_cnt  <= '0;
            pll_select <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            stab_cnt   <= stab_nxt;
            retry_cnt  <= retry_nxt;
            pll_select <= pll_sel_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        stab_nxt    = stab_cnt;
        retry_nxt   = retry_cnt;
        pll_sel_nxt = pll_select;

        // A rate change restarts everything, whatever else happens this cycle.
        if (rate_change_req) begin
            state_nxt   = RESET_HOLD;
            cnt_nxt     = '0;
            stab_nxt    = '0;
            retry_nxt   = '0;
            pll_sel_nxt = rate_sel;
        end else begin
            case (state)
                RESET_HOLD: begin
                    if (cnt >= HOLD_LAST) begin
                        state_nxt = WAIT_READY;
                        cnt_nxt   = '0;
                        stab_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WAIT_READY: begin
                    if (all_ok && (stab_cnt >= STAB_LAST)) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                        stab_nxt  = '0;
                        retry_nxt = '0;
                    end else if (!cal_busy && (cnt >= TMO_LAST)) begin
                        cnt_nxt   = '0;
                        stab_nxt  = '0;
                        retry_nxt = (retry_cnt >= RETRY_MAX) ? RETRY_MAX : retry_cnt + 4'd1;
                        state_nxt = (retry_nxt == RETRY_MAX) ? ERROR : RESET_HOLD;
                    end else begin
                        if (!all_ok) begin
                            stab_nxt = '0;
                        end else if (stab_cnt != STAB_MAX) begin
                            stab_nxt = stab_cnt + 1'b1;
                        end
                        // Calibration time does not count against the attempt.
                        if (!cal_busy && (cnt != CNT_MAX)) begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!all_ok) begin
                        state_nxt = RESET_HOLD;
                        cnt_nxt   = '0;
                        stab_nxt  = '0;
                    end
                end
                ERROR: begin
                    cnt_nxt  = '0;
                    stab_nxt = '0;
                end
                default: begin
                    state_nxt = RESET_HOLD;
                    cnt_nxt   = '0;
                    stab_nxt  = '0;
                end
            endcase
        end
    end

    // Outputs are a registered decode of the current state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xcvr_reset <= 1'b1;
            tx_data_en <= 1'b0;
            seq_busy   <= 1'b1;
            seq_error  <= 1'b0;
        end else begin
            xcvr_reset <= (state == RESET_HOLD) || (state == ERROR);
            tx_data_en <= (state == RUN);
            seq_busy   <= (state == RESET_HOLD) || (state == WAIT_READY);
            seq_error  <= (state == ERROR);
        end
    end

endmodule

// File: tb/tb_hdmi_tx_rst_seq.sv
// Directed bench for hdmi_tx_rst_seq with short hold/stable/timeout settings.
module tb_hdmi_tx_rst_seq;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rate_change_req;
    logic       rate_sel;
    logic       pll_locked;
    logic [3:0] tx_ready;
    logic [3:0] tx_cal_busy;
    logic       xcvr_reset;
    logic       pll_select;
    logic       tx_data_en;
    logic       seq_busy;
    logic       seq_error;
    logic [3:0] retry_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    hdmi_tx_rst_seq #(
        .NUM_LANES    (4),
        .RST_HOLD_CYC (4),
        .STABLE_CYC   (3),
        .TIMEOUT_CYC  (50),
        .MAX_RETRY    (2),
        .CNT_W        (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .rate_change_req (rate_change_req),
        .rate_sel        (rate_sel),
        .pll_locked      (pll_locked),
        .tx_ready        (tx_ready),
        .tx_cal_busy     (tx_cal_busy),
        .xcvr_reset      (xcvr_reset),
        .pll_select      (pll_select),
        .tx_data_en      (tx_data_en),
        .seq_busy        (seq_busy),
        .seq_error       (seq_error),
        .retry_cnt       (retry_cnt)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_xcvr_reset"}, 32'(xcvr_reset), 32'd1);
        chk({tag, "_pll_select"}, 32'(pll_select), 32'd0);
        chk({tag, "_tx_data_en"}, 32'(tx_data_en), 32'd0);
        chk({tag, "_seq_busy"},   32'(seq_busy),   32'd1);
        chk({tag, "_seq_error"},  32'(seq_error),  32'd0);
        chk({tag, "_retry_cnt"},  32'(retry_cnt),  32'd0);
    endtask

    initial begin
        reset_n         = 1'b0;
        rate_change_req = 1'b0;
        rate_sel        = 1'b0;
        pll_locked      = 1'b1;
        tx_ready        = 4'hF;
        tx_cal_busy     = 4'h0;
        tick(3);
        chk_reset_vals("por");

        // Bring-up: 4 hold cycles, then 3 stable cycles to RUN
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("bringup_hold", 32'(xcvr_reset), 32'd1);
        end
        tick(1);
        chk("bringup_release", 32'(xcvr_reset), 32'd0);
        chk("bringup_busy", 32'(seq_busy), 32'd1);
        tick(2);
        chk("bringup_not_yet_run", 32'(tx_data_en), 32'd0);
        tick(1);
        chk("bringup_run", 32'(tx_data_en), 32'd1);
        chk("bringup_busy_low", 32'(seq_busy), 32'd0);
        chk("bringup_retry", 32'(retry_cnt), 32'd0);

        // Lane 3 never ready: two timeouts lead to ERROR
        tx_ready = 4'h7;
        tick(1);
        chk("loss_lag", 32'(tx_data_en), 32'd1);
        tick(1);
        chk("loss_data_off", 32'(tx_data_en), 32'd0);
        chk("loss_retry", 32'(retry_cnt), 32'd0);
        tick(52);
        chk("tmo1_before", 32'(retry_cnt), 32'd0);
        tick(1);
        chk("tmo1_retry", 32'(retry_cnt), 32'd1);
        chk("tmo1_xcvr_lag", 32'(xcvr_reset), 32'd0);
        tick(1);
        chk("tmo1_xcvr", 32'(xcvr_reset), 32'd1);
        tick(52);
        chk("tmo2_before", 32'(retry_cnt), 32'd1);
        tick(1);
        chk("tmo2_retry", 32'(retry_cnt), 32'd2);
        chk("tmo2_err_lag", 32'(seq_error), 32'd0);
        tick(1);
        chk("err_flag", 32'(seq_error), 32'd1);
        chk("err_xcvr", 32'(xcvr_reset), 32'd1);
        chk("err_data", 32'(tx_data_en), 32'd0);
        chk("err_busy", 32'(seq_busy), 32'd0);
        tick(5);
        chk("err_sticky", 32'(seq_error), 32'd1);
        chk("err_retry_sat", 32'(retry_cnt), 32'd2);

        // Rate change out of ERROR
        rate_change_req = 1'b1;
        rate_sel        = 1'b1;
        tx_ready        = 4'hF;
        tick(1);
        rate_change_req = 1'b0;
        chk("rc_pll_select", 32'(pll_select), 32'd1);
        chk("rc_retry", 32'(retry_cnt), 32'd0);
        chk("rc_err_lag", 32'(seq_error), 32'd1);
        tick(1);
        chk("rc_err_clear", 32'(seq_error), 32'd0);
        chk("rc_xcvr_first", 32'(xcvr_reset), 32'd1);
        tick(3);
        chk("rc_xcvr_last", 32'(xcvr_reset), 32'd1);
        tick(1);
        chk("rc_xcvr_off", 32'(xcvr_reset), 32'd0);
        tick(2);
        chk("rc_not_yet_run", 32'(tx_data_en), 32'd0);
        tick(1);
        chk("rc_run", 32'(tx_data_en), 32'd1);

        // One-cycle glitch on lane 2 in RUN
        tx_ready = 4'hB;
        tick(1);
        tx_ready = 4'hF;
        chk("glitch_lag", 32'(tx_data_en), 32'd1);
        tick(1);
        chk("glitch_data_off", 32'(tx_data_en), 32'd0);
        chk("glitch_xcvr", 32'(xcvr_reset), 32'd1);
        chk("glitch_retry", 32'(retry_cnt), 32'd0);
        tick(6);
        chk("glitch_not_yet_run", 32'(tx_data_en), 32'd0);
        tick(1);
        chk("glitch_recover", 32'(tx_data_en), 32'd1);
        chk("glitch_retry_after", 32'(retry_cnt), 32'd0);

        // Calibration busy freezes the timeout
        tx_ready    = 4'h0;
        tx_cal_busy = 4'h1;
        tick(104);
        chk("cal_no_timeout", 32'(retry_cnt), 32'd0);
        chk("cal_busy_flag", 32'(seq_busy), 32'd1);
        tx_cal_busy = 4'h0;
        tick(49);
        chk("cal_tmo_before", 32'(retry_cnt), 32'd0);
        tick(1);
        chk("cal_tmo", 32'(retry_cnt), 32'd1);

        // Rate change on the timeout cycle wins over ERROR entry
        tick(53);
        rate_change_req = 1'b1;
        rate_sel        = 1'b0;
        tick(1);
        rate_change_req = 1'b0;
        tx_ready        = 4'hF;
        chk("race_retry", 32'(retry_cnt), 32'd0);
        chk("race_pll_select", 32'(pll_select), 32'd0);
        tick(1);
        chk("race_no_error", 32'(seq_error), 32'd0);
        chk("race_xcvr", 32'(xcvr_reset), 32'd1);

        // Rate change mid-hold restarts the hold count
        rate_change_req = 1'b1;
        rate_sel        = 1'b1;
        tick(1);
        rate_change_req = 1'b0;
        chk("rehold_pll_select", 32'(pll_select), 32'd1);
        tick(4);
        chk("rehold_xcvr_last", 32'(xcvr_reset), 32'd1);
        tick(1);
        chk("rehold_xcvr_off", 32'(xcvr_reset), 32'd0);
        tick(2);
        chk("rehold_not_yet_run", 32'(tx_data_en), 32'd0);
        tick(1);
        chk("rehold_run", 32'(tx_data_en), 32'd1);

        // PLL lock loss passes through the synchroniser
        pll_locked = 1'b0;
        tick(2);
        chk("pll_loss_sync1", 32'(tx_data_en), 32'd1);
        tick(1);
        chk("pll_loss_sync2", 32'(tx_data_en), 32'd1);
        tick(1);
        chk("pll_loss_off", 32'(tx_data_en), 32'd0);
        chk("pll_loss_retry", 32'(retry_cnt), 32'd0);
        pll_locked = 1'b1;
        tick(7);
        chk("pll_recover", 32'(tx_data_en), 32'd1);

        // Asynchronous reset in RUN
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_tx_rst_seq.md
Name: hdmi_tx_rst_seq

Overview:
Sequencer directly upstream of the 4-lane HDMI transceiver TX reset controller. Drives the controller's reset and pll_select, and consumes its tx_ready and the lanes' tx_cal_busy. Gates TMDS data launch (tx_data_en) until all lanes are stably ready. Re-runs the reset sequence on video-rate change or link loss, with bounded retries and an error flag.

Parameters:
NUM_LANES, 4, transceiver lanes (tx_ready/tx_cal_busy width)
RST_HOLD_CYC, 16, cycles xcvr_reset is held high per attempt (>=2)
STABLE_CYC, 8, consecutive cycles all lanes ready and PLL locked before RUN (>=1)
TIMEOUT_CYC, 1000000, WAIT_READY cycles before an attempt fails
MAX_RETRY, 3, failed attempts before ERROR (1..15)
CNT_W, 20, width of hold/timeout counter; must hold max(RST_HOLD_CYC, TIMEOUT_CYC)

Ports:
clock  in  1  system clock, same domain as reset controller
reset_n  in  1  asynchronous, active-low reset
rate_change_req  in  1  single-cycle request to switch TX rate
rate_sel  in  1  requested PLL select, sampled with rate_change_req
pll_locked  in  1  TX PLL lock, asynchronous; 2-FF synchronised internally
tx_ready  in  NUM_LANES  per-lane ready from reset controller (synchronous)
tx_cal_busy  in  NUM_LANES  per-lane calibration busy (synchronous)
xcvr_reset  out  1  active-high reset to reset controller
pll_select  out  1  PLL select to reset controller
tx_data_en  out  1  high only in RUN; enables TMDS data path
seq_busy  out  1  high in RESET_HOLD or WAIT_READY
seq_error  out  1  high in ERROR
retry_cnt  out  4  failed attempts since last RUN/rate change

Behaviour:
- Reset (reset_n low, async): state=RESET_HOLD, counter=0, xcvr_reset=1, pll_select=0, tx_data_en=0, seq_busy=1, seq_error=0, retry_cnt=0, sync flops=0.
- All outputs registered, decoded from state; one-cycle latency from state change.
- all_ok = (&tx_ready) & pll_locked_sync.
- RESET_HOLD: xcvr_reset=1; counter increments. At counter==RST_HOLD_CYC-1: counter clears, go WAIT_READY.
- WAIT_READY: xcvr_reset=0.
  - Stability counter increments while all_ok; clears on any cycle all_ok is low.
  - Reaching STABLE_CYC: go RUN, retry_cnt clears.
  - Timeout counter increments only when no tx_cal_busy bit is set (frozen during calibration).
  - Timeout at TIMEOUT_CYC: retry_cnt+1. If new value == MAX_RETRY go ERROR, else RESET_HOLD.
- RUN: tx_data_en=1. If all_ok is low for any single cycle: go RESET_HOLD; retry_cnt unchanged (link loss is not a failed attempt).
- ERROR: xcvr_reset=1 (lanes held in reset), seq_error=1. Exits only on rate_change_req.
- rate_change_req, any state: pll_select<=rate_sel next cycle; retry_cnt<=0; state<=RESET_HOLD; counters clear.
  - In RESET_HOLD this restarts the hold count.
  - It has priority over every other same-cycle transition, including timeout and stability completion.
- Counters saturate; no wrap. retry_cnt never exceeds MAX_RETRY.
- pll_locked is used only after its 2-FF sync: 2-cycle sync latency, so loss is seen in RUN at the earliest 3 cycles after the input falls.

Decomposition:
- Package hdmi_tx_rst_pkg: state enum (RESET_HOLD, WAIT_READY, RUN, ERROR) and default-parameter constants.
- One sub-module, hdmi_sync_2ff: 2-flop synchroniser with async active-low reset to 0, used for pll_locked.
- Sequencer FSM and counters in the top module.

Test Plan:
Bench parameters: RST_HOLD_CYC=4, STABLE_CYC=3, TIMEOUT_CYC=50, MAX_RETRY=2.
1. Release reset_n; tx_ready=4'hF, pll_locked=1 -> xcvr_reset high 4 cycles, then low; tx_data_en rises after 3 stable cycles plus sync latency; retry_cnt=0.
2. tx_ready=4'h7 held -> after 50 WAIT_READY cycles retry_cnt=1 and RESET_HOLD; second timeout -> retry_cnt=2, seq_error=1, xcvr_reset=1, tx_data_en=0.
3. In WAIT_READY, tx_cal_busy=4'h1 for 100 cycles, tx_ready=0 -> no timeout during busy; timeout fires 50 cycles after busy clears.
4. In RUN, tx_ready[2] drops 1 cycle -> tx_data_en=0 next cycle, RESET_HOLD; retry_cnt stays 0; recovers to RUN.
5. In ERROR, rate_change_req with rate_sel=1 -> pll_select=1, retry_cnt=0, seq_error=0, sequence restarts with xcvr_reset high 4 cycles.
6. In WAIT_READY, rate_change_req coincides with the timeout cycle -> RESET_HOLD, retry_cnt=0; hold count restarts; assert reset_n mid-RUN -> all outputs to reset values immediately.
